// File: rtl/serial_pkg.sv
// Shared types for the serial word receiver: FSM state encoding and the
// bit-order selector constants used for the MSB_First parameter.
package serial_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } rx_state_e;

    localparam bit LSB_FIRST = 1'b0;
    localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_rx_out_stage.sv
// Output stage of the serial word receiver: one-word holding register with a
// valid/ready handshake, the parity flag of the held word, and sticky overrun
// detection for completed words that arrive while the slot is still occupied.
module word_out_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmpl_i,
    input  logic [W-1:0] word_i,
    input  logic         perr_i,
    input  logic         ready_i,
    input  logic         clr_err_i,
    output logic [W-1:0] word_o,
    output logic         valid_o,
    output logic         perr_o,
    output logic         overrun_o
);

    logic [W-1:0] word_q, word_d;
    logic         valid_q, valid_d;
    logic         perr_q, perr_d;
    logic         ovr_q, ovr_d;
    logic         xfer, accept;

    // A completed word may take the slot if it is empty or being drained now;
    // otherwise it is dropped and flagged, and the held word stays intact.
    always_comb begin
        xfer    = valid_q & ready_i;
        accept  = cmpl_i & (~valid_q | xfer);
        word_d  = word_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        if (accept) begin
            word_d  = word_i;
            perr_d  = perr_i;
            valid_d = 1'b1;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
        // Set has priority over the clear request.
        if (cmpl_i && !accept) ovr_d = 1'b1;
        else if (clr_err_i)    ovr_d = 1'b0;
    end

    // Output-stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign word_o    = word_q;
    assign valid_o   = valid_q;
    assign perr_o    = perr_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver: samples one bit per Bit_Valid strobe, assembles
// width bits in the build-selected order and hands finished words to the
// output stage. Define SERIAL_RX_PARITY_EN to add a trailing even-parity bit
// per frame; without it Parity_Err is constant 0.
module serial_word_rx
    import serial_pkg::*;
#(
    parameter int width     = 8,
    parameter bit MSB_First = LSB_FIRST
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       Enable,
    input  logic                       Bit_Valid,
    input  logic                       S_DataIn,
    output logic [width-1:0]           Word_Out,
    output logic                       Word_Valid,
    input  logic                       Word_Ready,
    output logic                       Parity_Err,
    output logic                       Overrun,
    input  logic                       Clr_Err,
    output logic [$clog2(width+1)-1:0] Bit_Count
);

    localparam int CW = $clog2(width + 1);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    rx_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] asm_q, asm_d, shifted;
    logic             cmpl, cmpl_perr;
    logic [width-1:0] cmpl_word;

    // Assembly register with the new bit inserted in the configured order.
    always_comb begin
        if (MSB_First) shifted = {asm_q[width-2:0], S_DataIn};
        else           shifted = {S_DataIn, asm_q[width-1:1]};
    end

    // Next-state, bit counter and word-completion decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        cmpl      = 1'b0;
        cmpl_word = shifted;
        cmpl_perr = 1'b0;
        if (!Enable) begin
            state_d = COLLECT;
            cnt_d   = '0;
            asm_d   = '0;
        end else if (Bit_Valid) begin
            case (state_q)
                COLLECT: begin
                    asm_d = shifted;
                    if (cnt_q == LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = PARITY;
                        cnt_d   = CW'(width);
`else
                        cnt_d = '0;
                        cmpl  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    // Even parity: data bits plus parity bit must XOR to 0.
                    cmpl      = 1'b1;
                    cmpl_word = asm_q;
                    cmpl_perr = ^{asm_q, S_DataIn};
                    state_d   = COLLECT;
                    cnt_d     = '0;
                end
`endif
                default: state_d = COLLECT;
            endcase
        end
    end

    // Receive-side state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
        end
    end

    assign Bit_Count = cnt_q;

    word_out_stage #(.W(width)) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmpl_i    (cmpl),
        .word_i    (cmpl_word),
        .perr_i    (cmpl_perr),
        .ready_i   (Word_Ready),
        .clr_err_i (Clr_Err),
        .word_o    (Word_Out),
        .valid_o   (Word_Valid),
        .perr_o    (Parity_Err),
        .overrun_o (Overrun)
    );

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: two instances (LSB-first and MSB-first)
// share one stimulus stream; each scenario task checks its own results.
module tb_serial_word_rx;

`ifdef SERIAL_RX_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Enable = 1'b0, Bit_Valid = 1'b0, S_DataIn = 1'b0;
    logic       Word_Ready = 1'b0, Clr_Err = 1'b0;
    logic [7:0] wo_l, wo_m;
    logic       wv_l, wv_m, pe_l, pe_m, ov_l, ov_m;
    logic [3:0] bc_l, bc_m;

    int tests = 0;
    int fails = 0;
    int xfers = 0;

    always #5 clk = ~clk;

    serial_word_rx #(.width(8), .MSB_First(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .Enable(Enable), .Bit_Valid(Bit_Valid),
        .S_DataIn(S_DataIn), .Word_Out(wo_l), .Word_Valid(wv_l),
        .Word_Ready(Word_Ready), .Parity_Err(pe_l), .Overrun(ov_l),
        .Clr_Err(Clr_Err), .Bit_Count(bc_l));

    serial_word_rx #(.width(8), .MSB_First(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .Enable(Enable), .Bit_Valid(Bit_Valid),
        .S_DataIn(S_DataIn), .Word_Out(wo_m), .Word_Valid(wv_m),
        .Word_Ready(Word_Ready), .Parity_Err(pe_m), .Overrun(ov_m),
        .Clr_Err(Clr_Err), .Bit_Count(bc_m));

    always @(posedge clk) if (wv_l && Word_Ready) xfers++;

    // tx[0] is sent first; par is only sent in parity builds.
    task automatic send_frame(input logic [7:0] tx, input logic par, input bit rdy_last);
        logic [8:0] f;
        f = {par, tx};
        for (int i = 0; i < FB; i++) begin
            Bit_Valid = 1'b1;
            S_DataIn  = f[i];
            if (rdy_last && i == FB - 1) Word_Ready = 1'b1;
            @(negedge clk);
        end
        if (rdy_last) Word_Ready = 1'b0;
        Bit_Valid = 1'b0;
    endtask

    task automatic consume();
        Word_Ready = 1'b1;
        @(negedge clk);
        Word_Ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({wo_l, wv_l, pe_l, ov_l, bc_l} !== 15'd0) begin
            fails++;
            $display("FAIL reset_lsb: got word=%h v=%b pe=%b ov=%b cnt=%0d, want all 0", wo_l, wv_l, pe_l, ov_l, bc_l);
        end
        tests++;
        if ({wo_m, wv_m, pe_m, ov_m, bc_m} !== 15'd0) begin
            fails++;
            $display("FAIL reset_msb: got word=%h v=%b pe=%b ov=%b cnt=%0d, want all 0", wo_m, wv_m, pe_m, ov_m, bc_m);
        end
    endtask

    task automatic test_ordering();
        send_frame(8'h4D, 1'b0, 0);
        tests++;
        if (wv_l !== 1'b1 || wo_l !== 8'h4D) begin
            fails++; $display("FAIL order_lsb: got v=%b word=%h, want v=1 word=4d", wv_l, wo_l);
        end
        tests++;
        if (wv_m !== 1'b1 || wo_m !== 8'hB2) begin
            fails++; $display("FAIL order_msb: got v=%b word=%h, want v=1 word=b2", wv_m, wo_m);
        end
`ifndef SERIAL_RX_PARITY_EN
        tests++;
        if (pe_l !== 1'b0 || pe_m !== 1'b0) begin
            fails++; $display("FAIL perr_tied: got %b/%b, want 0/0", pe_l, pe_m);
        end
`endif
        consume();
        tests++;
        if (wv_l !== 1'b0 || wo_l !== 8'h4D || bc_l !== 4'd0) begin
            fails++; $display("FAIL drain: got v=%b word=%h cnt=%0d, want v=0 word=4d cnt=0", wv_l, wo_l, bc_l);
        end
    endtask

    task automatic test_back_to_back();
        int x0;
        x0 = xfers;
        Word_Ready = 1'b1;
        send_frame(8'h3C, ^8'h3C, 0);
        tests++;
        if (wv_l !== 1'b1 || wo_l !== 8'h3C) begin
            fails++; $display("FAIL b2b_w0: got v=%b word=%h, want v=1 word=3c", wv_l, wo_l);
        end
        send_frame(8'hC3, ^8'hC3, 0);
        tests++;
        if (wv_l !== 1'b1 || wo_l !== 8'hC3) begin
            fails++; $display("FAIL b2b_w1: got v=%b word=%h, want v=1 word=c3", wv_l, wo_l);
        end
        @(negedge clk);
        Word_Ready = 1'b0;
        tests++;
        if (xfers - x0 != 2 || ov_l !== 1'b0 || wv_l !== 1'b0) begin
            fails++; $display("FAIL b2b_xfer: got xfers=%0d ov=%b v=%b, want 2 0 0", xfers - x0, ov_l, wv_l);
        end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, ^8'h11, 0);
        send_frame(8'h22, ^8'h22, 0);
        tests++;
        if (wv_l !== 1'b1 || wo_l !== 8'h11 || ov_l !== 1'b1) begin
            fails++; $display("FAIL overrun: got v=%b word=%h ov=%b, want 1 11 1", wv_l, wo_l, ov_l);
        end
        Clr_Err = 1'b1;
        @(negedge clk);
        Clr_Err = 1'b0;
        tests++;
        if (ov_l !== 1'b0 || wo_l !== 8'h11 || wv_l !== 1'b1) begin
            fails++; $display("FAIL clr_err: got ov=%b word=%h v=%b, want 0 11 1", ov_l, wo_l, wv_l);
        end
    endtask

    task automatic test_same_cycle();
        // Word 11 is still held from the overrun scenario.
        send_frame(8'h5A, ^8'h5A, 1);
        tests++;
        if (wv_l !== 1'b1 || wo_l !== 8'h5A || ov_l !== 1'b0) begin
            fails++; $display("FAIL same_cycle: got v=%b word=%h ov=%b, want 1 5a 0", wv_l, wo_l, ov_l);
        end
        consume();
    endtask

    task automatic test_abort();
        for (int i = 0; i < 5; i++) begin
            Bit_Valid = 1'b1; S_DataIn = 1'b1;
            @(negedge clk);
        end
        Bit_Valid = 1'b0;
        tests++;
        if (bc_l !== 4'd5) begin
            fails++; $display("FAIL abort_cnt5: got %0d, want 5", bc_l);
        end
        Enable = 1'b0; Bit_Valid = 1'b1;
        @(negedge clk);
        Bit_Valid = 1'b0;
        tests++;
        if (bc_l !== 4'd0) begin
            fails++; $display("FAIL abort_clear: got cnt=%0d, want 0", bc_l);
        end
        Enable = 1'b1;
        send_frame(8'hA5, ^8'hA5, 0);
        tests++;
        if (wv_l !== 1'b1 || wo_l !== 8'hA5 || bc_l !== 4'd0 || ov_l !== 1'b0) begin
            fails++; $display("FAIL abort_word: got v=%b word=%h cnt=%0d ov=%b, want 1 a5 0 0", wv_l, wo_l, bc_l, ov_l);
        end
        consume();
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h03, 1'b0, 0);
        tests++;
        if (wv_l !== 1'b1 || wo_l !== 8'h03 || pe_l !== 1'b0) begin
            fails++; $display("FAIL parity_ok: got v=%b word=%h pe=%b, want 1 03 0", wv_l, wo_l, pe_l);
        end
        consume();
        send_frame(8'h07, 1'b0, 0);
        tests++;
        if (wv_l !== 1'b1 || wo_l !== 8'h07 || pe_l !== 1'b1 || pe_m !== 1'b1) begin
            fails++; $display("FAIL parity_bad: got v=%b word=%h pe=%b/%b, want 1 07 1/1", wv_l, wo_l, pe_l, pe_m);
        end
        consume();
    endtask
`endif

    task automatic test_reset_mid();
        send_frame(8'h99, ^8'h99, 0);
        send_frame(8'h66, ^8'h66, 0);
        for (int i = 0; i < 3; i++) begin
            Bit_Valid = 1'b1; S_DataIn = 1'b1;
            @(negedge clk);
        end
        Bit_Valid = 1'b0;
        tests++;
        if (wv_l !== 1'b1 || ov_l !== 1'b1 || bc_l !== 4'd3) begin
            fails++; $display("FAIL pre_reset: got v=%b ov=%b cnt=%0d, want 1 1 3", wv_l, ov_l, bc_l);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({wo_l, wv_l, pe_l, ov_l, bc_l, wo_m, wv_m, bc_m} !== 21'd0) begin
            fails++; $display("FAIL async_reset: got word=%h v=%b pe=%b ov=%b cnt=%0d, want all 0", wo_l, wv_l, pe_l, ov_l, bc_l);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        Enable = 1'b1;
        @(negedge clk);
        test_ordering();
        test_back_to_back();
        test_overrun();
        test_same_cycle();
        test_abort();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel receive stage that sits directly downstream of the shift register's serial output. It samples one bit per `Bit_Valid` strobe and assembles `width` bits into a word, in an order selectable at build time. Each completed word goes out on a valid/ready handshake with a one-word holding register. Optionally, an even-parity bit that trails the data is checked.

## Interface
- `width`, default 8: data bits per word; legal values 2 and up.
- `MSB_First`, default 0:
  - 0: first received bit lands in `Word_Out[0]`. This matches right-shift serial output.
  - 1: first received bit lands in `Word_Out[width-1]`. This matches left-shift output.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `Enable`  in  1  receiver enable; low aborts any partial word.
- `Bit_Valid`  in  1  `S_DataIn` carries a valid bit this cycle.
- `S_DataIn`  in  1  serial data bit.
- `Word_Out`  out  width  assembled word; stable while `Word_Valid` is high.
- `Word_Valid`  out  1  `Word_Out` holds an unconsumed word.
- `Word_Ready`  in  1  consumer accepts the word; transfer occurs when `Word_Valid` and `Word_Ready` are both high.
- `Parity_Err`  out  1  parity mismatch for the word currently in `Word_Out`.
- `Overrun`  out  1  sticky flag: a completed word was dropped.
- `Clr_Err`  in  1  synchronous clear of `Overrun`.
- `Bit_Count`  out  $clog2(width+1)  number of bits of the current frame received so far.

## Operation
- State machine:
  - `COLLECT`: shift in data bits.
  - `PARITY`: wait for the parity bit. This state exists only when `SERIAL_RX_PARITY_EN` is defined.
- In `COLLECT`, each `Bit_Valid` shifts `S_DataIn` into the assembly register:
  - `MSB_First`=0: shift right, new bit enters at the MSB. After `width` bits, the first bit is at bit 0.
  - `MSB_First`=1: shift left, new bit enters at the LSB.
  - `Bit_Count` increments on each bit.
- The bit that makes `Bit_Count` equal `width`:
  - Without parity: completes the word. `Bit_Count` returns to 0 and the state stays `COLLECT`.
  - With parity: moves the state to `PARITY`.
- In `PARITY`, the next `Bit_Valid` completes the word.
  - Mismatch when the XOR of the data bits and the parity bit is 1 (even parity).
  - Then return to `COLLECT` with `Bit_Count`=0.
- Word completion, judged against output-stage state at the same edge:
  - `Word_Valid`=0, or a transfer happens in the same cycle: load `Word_Out` and `Parity_Err`, and set `Word_Valid`=1.
  - Otherwise the new word is discarded, `Overrun` is set, and the held word is left untouched.
- Transfer without a same-cycle completion: `Word_Valid` drops to 0 on the next edge. `Word_Out` keeps its last value.
- `Enable`=0:
  - Clear the assembly register and `Bit_Count`, and force `COLLECT`.
  - `Bit_Valid` is ignored.
  - The output stage and handshake keep working, so a held word can still be consumed.
- `Clr_Err`:
  - Clears `Overrun`.
  - If an overrun event occurs in the same cycle, the set wins.
- `Bit_Valid` may be asserted every cycle. There is no minimum gap between bits.

## Timing
- Reset values: `Word_Out`=0, `Word_Valid`=0, `Parity_Err`=0, `Overrun`=0, `Bit_Count`=0, state=`COLLECT`, assembly register=0.
- Latency: `Word_Valid` rises on the first clock edge after the cycle holding the completing `Bit_Valid`.
- Throughput: one word per `width` (or `width+1`) bit strobes, with no dead cycles, provided `Word_Ready` is held high.
- `Word_Valid` never depends combinationally on `Word_Ready`. All outputs are registered.
- Reset asserted mid-frame: the partial word is lost, and everything returns to the reset values immediately (asynchronous).

## Configuration
- `SERIAL_RX_PARITY_EN` defined:
  - The `PARITY` state is built in.
  - Each frame is `width`+1 bits.
  - `Parity_Err` is computed as described above.
- `SERIAL_RX_PARITY_EN` not defined:
  - Each frame is `width` bits.
  - The `PARITY` state is absent.
  - The `Parity_Err` port remains but is tied to 0.

## Structure
- Package `serial_pkg` holds:
  - the state enum (`COLLECT`, `PARITY`);
  - the bit-order constants `LSB_FIRST`=0 and `MSB_FIRST`=1.
- Sub-module `word_out_stage` holds:
  - the holding register, `Word_Valid`, `Parity_Err` and the handshake logic;
  - overrun detection.
- The top level keeps the state machine, the bit counter and the assembly register.

## Test plan
- Ordering, `width`=8, `MSB_First`=0, no parity: bits 1,0,1,1,0,0,1,0 on consecutive strobes -> `Word_Out`=8'h4D and `Word_Valid`=1 one cycle after the last strobe. With `MSB_First`=1 the same bits -> `Word_Out`=8'hB2.
- Back-to-back: 16 consecutive strobes with `Word_Ready`=1 -> two words transferred with no gap and no `Overrun`.
- Overrun: hold `Word_Ready`=0 and send two full words -> the first word stays in `Word_Out` and `Overrun`=1. Then pulse `Clr_Err` -> `Overrun`=0.
- Same-cycle completion and transfer: a word is held, `Word_Ready`=1 in the cycle of the 8th strobe -> the new word loads, `Word_Valid` stays 1, and `Overrun` stays 0.
- Abort: after 5 bits drop `Enable` for one cycle, then send 8 bits of 8'hA5 -> `Word_Out`=8'hA5 and `Bit_Count` has returned to 0.
- Parity (macro defined): 8'h03 followed by parity bit 0 -> `Parity_Err`=0. 8'h07 followed by parity bit 0 -> `Parity_Err`=1. Also assert `rst_n` low mid-frame -> all outputs read 0 at once.
